// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU operand-issue stage.
// Holds the ALU opcode encoding, the instruction-word field layout and
// the issue FSM state type.
package alu_issue_pkg;

    typedef enum logic [3:0] {
        OP_SHL  = 4'd0,
        OP_SHR  = 4'd1,
        OP_ASHR = 4'd2,
        OP_MOD  = 4'd3,
        OP_DIV  = 4'd4,
        OP_MUL  = 4'd5,
        OP_SUB  = 4'd6,
        OP_ADD  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOT  = 4'd11
    } alu_op_e;

    // Instruction word: [3:0] op, [6:4] rd, [9:7] rs1, [12:10] rs2, [13] imm, [15:14] reserved
    localparam int unsigned OP_LSB  = 0;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned RD_LSB  = 4;
    localparam int unsigned RS1_LSB = 7;
    localparam int unsigned RS2_LSB = 10;
    localparam int unsigned IMM_BIT = 13;

    typedef enum logic {
        S_OP,
        S_IMM
    } issue_state_e;

endpackage

// File: rtl/alu_operand_bypass.sv
// Operand select for one register-file read port: a writeback landing on
// the same register in the same cycle wins over the (stale) read data.
// Ports:
//   rd_addr  - register being read
//   rf_data  - asynchronous register-file read data for rd_addr
//   wb_valid - register-file write this cycle
//   wb_addr  - write address
//   wb_data  - write data
//   operand  - bypassed operand value
module alu_operand_bypass #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 16
) (
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rf_data,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] operand
);

    assign operand = (wb_valid && (wb_addr == rd_addr)) ? wb_data : rf_data;

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage feeding the 16-bit ALU. Accepts instruction words
// (optionally followed by an immediate word), reads and bypasses register
// operands and presents a registered op to the ALU with a valid/ready
// handshake on both sides.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - input word handshake, in_word is the word
//   rf_addr_a/b           - register-file read addresses (rs1/rs2 of in_word)
//   rf_data_a/b           - asynchronous register-file read data
//   wb_valid/addr/data    - same-cycle register-file writeback for bypass
//   alu_instruction       - opcode in [3:0], upper bits zero
//   alu_input_1/2         - ALU operands
//   alu_enable            - op valid (out_valid)
//   alu_rd                - destination register of the issued op
//   out_ready             - downstream consumes the issued op
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_word,
    output logic [REG_AW-1:0] rf_addr_a,
    output logic [REG_AW-1:0] rf_addr_b,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] alu_instruction,
    output logic [DATA_W-1:0] alu_input_1,
    output logic [DATA_W-1:0] alu_input_2,
    output logic              alu_enable,
    output logic [REG_AW-1:0] alu_rd,
    input  logic              out_ready
);

    issue_state_e      state;
    logic [OP_W-1:0]   hold_op;
    logic [REG_AW-1:0] hold_rd;
    logic [DATA_W-1:0] hold_in1;

    logic [DATA_W-1:0] byp_a;
    logic [DATA_W-1:0] byp_b;
    logic              accept;
    logic [OP_W-1:0]   word_op;
    logic [REG_AW-1:0] word_rd;

    assign rf_addr_a = in_word[RS1_LSB +: REG_AW];
    assign rf_addr_b = in_word[RS2_LSB +: REG_AW];
    assign word_op   = in_word[OP_LSB +: OP_W];
    assign word_rd   = in_word[RD_LSB +: REG_AW];

    // Output slot is free when empty or being drained this cycle.
    assign in_ready = !alu_enable || out_ready;
    assign accept   = in_valid && in_ready;

    alu_operand_bypass #(
        .AW (REG_AW),
        .DW (DATA_W)
    ) u_byp_a (
        .rd_addr  (rf_addr_a),
        .rf_data  (rf_data_a),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .operand  (byp_a)
    );

    alu_operand_bypass #(
        .AW (REG_AW),
        .DW (DATA_W)
    ) u_byp_b (
        .rd_addr  (rf_addr_b),
        .rf_data  (rf_data_b),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .operand  (byp_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_OP;
            hold_op         <= '0;
            hold_rd         <= '0;
            hold_in1        <= '0;
            alu_enable      <= 1'b0;
            alu_instruction <= '0;
            alu_input_1     <= '0;
            alu_input_2     <= '0;
            alu_rd          <= '0;
        end else begin
            // Consumed op drops valid; data outputs keep their last value.
            if (alu_enable && out_ready) begin
                alu_enable <= 1'b0;
            end
            if (accept) begin
                case (state)
                    S_OP: begin
                        if (in_word[IMM_BIT]) begin
                            // rs1 is captured now; later writebacks do not refresh it.
                            hold_op  <= word_op;
                            hold_rd  <= word_rd;
                            hold_in1 <= byp_a;
                            state    <= S_IMM;
                        end else begin
                            alu_instruction <= {{(DATA_W-OP_W){1'b0}}, word_op};
                            alu_rd          <= word_rd;
                            alu_input_1     <= byp_a;
                            alu_input_2     <= byp_b;
                            alu_enable      <= 1'b1;
                        end
                    end
                    S_IMM: begin
                        alu_instruction <= {{(DATA_W-OP_W){1'b0}}, hold_op};
                        alu_rd          <= hold_rd;
                        alu_input_1     <= hold_in1;
                        alu_input_2     <= in_word;
                        alu_enable      <= 1'b1;
                        state           <= S_OP;
                    end
                    default: state <= S_OP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic [2:0]  rf_addr_a;
    logic [2:0]  rf_addr_b;
    logic [15:0] rf_data_a;
    logic [15:0] rf_data_b;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] alu_instruction;
    logic [15:0] alu_input_1;
    logic [15:0] alu_input_2;
    logic        alu_enable;
    logic [2:0]  alu_rd;
    logic        out_ready;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_on = 1'b0;

    alu_issue_stage dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_word         (in_word),
        .rf_addr_a       (rf_addr_a),
        .rf_addr_b       (rf_addr_b),
        .rf_data_a       (rf_data_a),
        .rf_data_b       (rf_data_b),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .alu_instruction (alu_instruction),
        .alu_input_1     (alu_input_1),
        .alu_input_2     (alu_input_2),
        .alu_enable      (alu_enable),
        .alu_rd          (alu_rd),
        .out_ready       (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file owned by the bench.
    logic [15:0] rf_mem [8];
    assign rf_data_a = rf_mem[rf_addr_a];
    assign rf_data_b = rf_mem[rf_addr_b];
    always @(posedge clk) begin
        if (wb_valid) rf_mem[wb_addr] <= wb_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    int m_en, m_instr, m_in1, m_in2, m_rd;
    int m_wait_imm, m_h_op, m_h_rd, m_h_in1;
    logic m_rdy;
    assign m_rdy = (m_en == 0) || out_ready;

    function automatic int opval(input int r);
        if (wb_valid && int'(wb_addr) == r) return int'(wb_data);
        return int'(rf_mem[r]);
    endfunction

    always @(posedge clk) begin
        int w;
        w = int'(in_word);
        if (rst) begin
            m_en <= 0; m_instr <= 0; m_in1 <= 0; m_in2 <= 0; m_rd <= 0;
            m_wait_imm <= 0; m_h_op <= 0; m_h_rd <= 0; m_h_in1 <= 0;
        end else begin
            if (m_en != 0 && out_ready) m_en <= 0;
            if (in_valid && m_rdy) begin
                if (m_wait_imm != 0) begin
                    m_instr <= m_h_op; m_rd <= m_h_rd; m_in1 <= m_h_in1; m_in2 <= w;
                    m_en <= 1; m_wait_imm <= 0;
                end else if ((w / 8192) % 2 == 1) begin
                    m_h_op <= w % 16; m_h_rd <= (w / 16) % 8;
                    m_h_in1 <= opval((w / 128) % 8); m_wait_imm <= 1;
                end else begin
                    m_instr <= w % 16; m_rd <= (w / 16) % 8;
                    m_in1 <= opval((w / 128) % 8); m_in2 <= opval((w / 1024) % 8);
                    m_en <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("enable",   32'(alu_enable),      m_en);
            check("instr",    32'(alu_instruction), m_instr);
            check("input_1",  32'(alu_input_1),     m_in1);
            check("input_2",  32'(alu_input_2),     m_in2);
            check("rd",       32'(alu_rd),          m_rd);
            check("in_ready", 32'(in_ready),        32'(m_rdy));
            check("rf_addr_a", 32'(rf_addr_a), (int'(in_word) / 128) % 8);
            check("rf_addr_b", 32'(rf_addr_b), (int'(in_word) / 1024) % 8);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        in_valid = 1'b1;
        in_word  = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        step();
        wb_valid = 1'b0;
    endtask

    function automatic logic [15:0] stream_word(input int i);
        int w;
        w = i + (i % 8) * 16 + (i % 8) * 128 + ((i + 1) % 8) * 1024;
        if (i % 2 == 1) w = w + 32'hC000;  // reserved bits must be ignored
        return 16'(w);
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_word = 16'h0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
        step();
        chk_on = 1'b1;
        for (int i = 0; i < 8; i++) wb_write(3'(i), 16'(32'h1000 + i * 32'h11));
        wb_write(3'd1, 16'd5);
        wb_write(3'd2, 16'd7);
        check("reset_enable", 32'(alu_enable), 0);
        check("reset_instr", 32'(alu_instruction), 0);
        rst = 1'b0;
        step();

        // Register-form ADD r3 = r1 + r2
        send(16'h08B7);
        check("add_en", 32'(alu_enable), 1);
        check("add_in1", 32'(alu_input_1), 5);
        check("add_in2", 32'(alu_input_2), 7);
        check("add_instr", 32'(alu_instruction), 16'h0007);
        check("add_rd", 32'(alu_rd), 3);

        // Immediate SUB r5 = r1 - 40, r1 = 100
        wb_write(3'd1, 16'd100);
        send(16'h20D6);
        check("imm_first_en", 32'(alu_enable), 0);
        send(16'h0028);
        check("imm_en", 32'(alu_enable), 1);
        check("imm_in1", 32'(alu_input_1), 100);
        check("imm_in2", 32'(alu_input_2), 40);
        check("imm_instr", 32'(alu_instruction), 6);
        check("imm_rd", 32'(alu_rd), 5);

        // Same-cycle writeback bypass on both operands
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'hBEEF;
        send(16'h0917);
        wb_valid = 1'b0;
        check("byp_in1", 32'(alu_input_1), 16'hBEEF);
        check("byp_in2", 32'(alu_input_2), 16'hBEEF);
        check("byp_rd", 32'(alu_rd), 1);
        step();

        // Backpressure: op pending for 3 cycles, next op waits
        out_ready = 1'b0;
        send(16'h08B7);
        check("bp_en", 32'(alu_enable), 1);
        in_valid = 1'b1; in_word = 16'h0526;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_stall_ready", 32'(in_ready), 0);
            check("bp_stall_in1", 32'(alu_input_1), 100);
            check("bp_stall_in2", 32'(alu_input_2), 16'hBEEF);
            check("bp_stall_instr", 32'(alu_instruction), 7);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("bp_next_en", 32'(alu_enable), 1);
        check("bp_next_instr", 32'(alu_instruction), 6);
        check("bp_next_in1", 32'(alu_input_1), 16'hBEEF);
        check("bp_next_in2", 32'(alu_input_2), 100);
        check("bp_next_rd", 32'(alu_rd), 2);
        step();

        // Reset while waiting for an immediate word
        send(16'h20D6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_en", 32'(alu_enable), 0);
        check("rst_instr", 32'(alu_instruction), 0);
        send(16'h08B7);
        check("rst_next_en", 32'(alu_enable), 1);
        check("rst_next_instr", 32'(alu_instruction), 7);
        check("rst_next_in1", 32'(alu_input_1), 100);
        check("rst_next_in2", 32'(alu_input_2), 16'hBEEF);

        // Streaming: 8 back-to-back ops
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_word = stream_word(i);
            step();
            check("stream_en", 32'(alu_enable), 1);
            check("stream_instr", 32'(alu_instruction), i);
            check("stream_rd", 32'(alu_rd), i % 8);
            if (i == 1) begin
                check("stream1_in1", 32'(alu_input_1), 100);
                check("stream1_in2", 32'(alu_input_2), 16'hBEEF);
            end
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 32'(alu_enable), 0);
        check("stream_hold_instr", 32'(alu_instruction), 7);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
